// File: rtl/hs_pkg.sv
// Shared definitions for the host-side command FIS transmitter.
// Contents: FSM state encoding, the Register H2D FIS type code, the default
// FIS length in dwords, and the widths of the word index and retry counter.
package hs_pkg;

  localparam int          HS_FIS_DWORDS_DEF = 5;
  localparam logic [7:0]  HS_FIS_TYPE_H2D   = 8'h27;
  localparam int          HS_RETRY_W        = 4;   // holds 0..15 retries
  localparam int          HS_IDX_W          = 5;   // holds dword index 0..31

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_WSTAT = 3'd3,
    ST_DONE  = 3'd4
  } hs_state_e;

  // True when a dword carries the Register H2D FIS type in its low byte.
  function automatic logic is_reg_h2d(input logic [31:0] dw);
    return dw[7:0] == HS_FIS_TYPE_H2D;
  endfunction

endpackage

// File: rtl/hs_tmo_cnt.sv
// Generic watchdog counter.
// Counts enabled cycles since the last clear and flags the cycle in which
// the C_LIMIT-th enabled cycle occurs.
// Ports:
//   clk   in  clock
//   srst  in  synchronous active-high reset
//   clr   in  clear count to zero (dominates enable)
//   en    in  count this cycle
//   tc    out terminal count: high during the C_LIMIT-th enabled cycle
module hs_tmo_cnt #(
  parameter int C_LIMIT = 65535
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (C_LIMIT > 1) ? $clog2(C_LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(C_LIMIT - 1);

  logic [W-1:0] count_reg;

  assign tc = en && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hs_cmd_fis_tx.sv
// Register H2D FIS transmitter.
// Fetches C_FIS_DWORDS words from the host command slot and streams them to
// the link layer, waits for the frame status, retries up to C_RETRY times on
// R_ERR, aborts on PHY loss and reports completion with a one-cycle cmd_done.
// Optional build macro HS_CMD_TMO_EN: a status-wait watchdog of C_TMO_CYCLES
// cycles that treats a missing status as R_ERR.
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   PhyReady                  link/PHY up
//   cmd_req                   command pending (level)
//   cmd_done, cmd_err         completion pulse and its status
//   cmd_raddr, cmd_rdata      command slot read port (1-cycle read latency)
//   tx_data, tx_valid, tx_sof, tx_eof, tx_ready   link transmit word stream
//   tx_stat_vld, tx_stat_err  link frame status strobe
module hs_cmd_fis_tx
  import hs_pkg::*;
#(
  parameter int C_FIS_DWORDS = HS_FIS_DWORDS_DEF,
  parameter int C_RETRY      = 3,
  parameter int C_TMO_CYCLES = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        PhyReady,
  input  logic        cmd_req,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [4:0]  cmd_raddr,
  input  logic [31:0] cmd_rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_sof,
  output logic        tx_eof,
  input  logic        tx_ready,
  input  logic        tx_stat_vld,
  input  logic        tx_stat_err
);

  if (C_FIS_DWORDS < 1 || C_FIS_DWORDS > 32 || C_RETRY < 0 || C_RETRY > 15 ||
      C_TMO_CYCLES < 1) begin : g_param_err
    $error("hs_cmd_fis_tx: parameter out of range");
  end

  localparam logic [HS_IDX_W-1:0]   LAST_IDX  = HS_IDX_W'(C_FIS_DWORDS - 1);
  localparam logic [HS_RETRY_W-1:0] RETRY_MAX = HS_RETRY_W'(C_RETRY);

  hs_state_e               state_reg;
  logic [HS_IDX_W-1:0]     idx_reg;
  logic [HS_RETRY_W-1:0]   retry_reg;
  logic [4:0]              raddr_reg;
  logic [31:0]             tx_data_reg;
  logic                    tx_valid_reg;
  logic                    tx_sof_reg;
  logic                    tx_eof_reg;
  logic                    done_reg;
  logic                    err_reg;

  // Frame status event and whether it means "retransmit".
  logic stat_evt;
  logic stat_bad;

`ifdef HS_CMD_TMO_EN
  logic tmo_hit;

  // Counter is held clear outside WSTAT, so it restarts on every entry.
  hs_tmo_cnt #(
    .C_LIMIT (C_TMO_CYCLES)
  ) u_tmo (
    .clk  (sys_clk),
    .srst (sys_rst),
    .clr  (state_reg != ST_WSTAT),
    .en   (state_reg == ST_WSTAT),
    .tc   (tmo_hit)
  );

  assign stat_evt = tx_stat_vld | tmo_hit;
  assign stat_bad = tx_stat_vld ? tx_stat_err : 1'b1;
`else
  assign stat_evt = tx_stat_vld;
  assign stat_bad = tx_stat_err;
`endif

  assign cmd_done  = done_reg;
  assign cmd_err   = err_reg;
  assign cmd_raddr = raddr_reg;
  assign tx_data   = tx_data_reg;
  assign tx_valid  = tx_valid_reg;
  assign tx_sof    = tx_sof_reg;
  assign tx_eof    = tx_eof_reg;

  // cmd_raddr always points at the word the next FETCH will capture, one
  // cycle ahead, because the slot read data lags the address by a cycle:
  //   - held at 0 through DONE/IDLE for the first word,
  //   - advanced to index+1 when a non-last word is loaded, so the data is
  //     ready by the FETCH that follows its acceptance,
  //   - rewound to 0 once the last word is accepted, ready for a retry.
  // It therefore never exceeds C_FIS_DWORDS-1 and stops moving on abort.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      retry_reg    <= '0;
      raddr_reg    <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      tx_sof_reg   <= 1'b0;
      tx_eof_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          raddr_reg <= '0;
          if (cmd_req && PhyReady) begin
            idx_reg   <= '0;
            retry_reg <= '0;
            state_reg <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (!PhyReady) begin
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            tx_data_reg  <= cmd_rdata;
            tx_valid_reg <= 1'b1;
            tx_sof_reg   <= (idx_reg == '0);
            tx_eof_reg   <= (idx_reg == LAST_IDX);
            if (idx_reg != LAST_IDX) begin
              raddr_reg <= idx_reg + 1'b1;
            end
            state_reg <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!PhyReady) begin
            // Abort wins over a same-cycle accept; link drops the partial frame.
            tx_valid_reg <= 1'b0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
            done_reg     <= 1'b1;
            err_reg      <= 1'b1;
            state_reg    <= ST_DONE;
          end else if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              raddr_reg <= '0;
              state_reg <= ST_WSTAT;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= ST_FETCH;
            end
          end
        end

        ST_WSTAT: begin
          if (!PhyReady) begin
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else if (stat_evt) begin
            if (!stat_bad) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else if (retry_reg < RETRY_MAX) begin
              retry_reg <= retry_reg + 1'b1;
              idx_reg   <= '0;
              raddr_reg <= '0;
              state_reg <= ST_FETCH;
            end else begin
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // cmd_done is high for this one cycle; IDLE looks at cmd_req next.
          raddr_reg <= '0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
